// File: rtl/bram_pkg.sv
// Shared types and limits for the dual-port byte-write block RAM.
package bram_pkg;

  typedef enum logic [1:0] {
    WR_FIRST,
    RD_FIRST,
    NO_CHANGE
  } wr_mode_e;

  localparam int unsigned MaxReadLatency = 3;

endpackage

// File: rtl/bram_out_pipe.sv
// Valid-gated output register chain for one BRAM port: stage 0 up to rdata/rvalid.
module bram_out_pipe #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Stages    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o
);

  logic [DataWidth-1:0] data_d [Stages];
  logic [DataWidth-1:0] data_q [Stages];
  logic [Stages-1:0]    valid_d, valid_q;

  // Each stage only loads when the valid bit feeding it is set, so data holds between pulses.
  always_comb begin
    valid_d    = '0;
    data_d     = data_q;
    valid_d[0] = valid_i;
    if (valid_i) data_d[0] = data_i;
    for (int unsigned k = 1; k < Stages; k++) begin
      valid_d[k] = valid_q[k-1];
      if (valid_q[k-1]) data_d[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < Stages; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q[Stages-1];
  assign valid_o = valid_q[Stages-1];

endmodule

// File: rtl/xilinx_dp_bram_pipe.sv
// True dual-port byte-write BRAM with per-port write mode, pipelined reads and collision flag.
module xilinx_dp_bram_pipe
  import bram_pkg::*;
#(
  parameter int unsigned NB_COL       = 4,
  parameter int unsigned COL_WIDTH    = 8,
  parameter int unsigned RAM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter wr_mode_e    WRITE_MODE_A = WR_FIRST,
  parameter wr_mode_e    WRITE_MODE_B = WR_FIRST,
  localparam int unsigned AddrWidth   = $clog2(RAM_DEPTH),
  localparam int unsigned DataWidth   = NB_COL * COL_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 a_req_i,
  input  logic                 a_we_i,
  input  logic [NB_COL-1:0]    a_be_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_wdata_i,
  output logic [DataWidth-1:0] a_rdata_o,
  output logic                 a_rvalid_o,
  input  logic                 b_req_i,
  input  logic                 b_we_i,
  input  logic [NB_COL-1:0]    b_be_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  input  logic [DataWidth-1:0] b_wdata_i,
  output logic [DataWidth-1:0] b_rdata_o,
  output logic                 b_rvalid_o,
  output logic                 collision_o
);

  if (READ_LATENCY < 1 || READ_LATENCY > MaxReadLatency) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..3");
  end
  if (RAM_DEPTH < 2 || (RAM_DEPTH & (RAM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAM_DEPTH must be a power of 2 and at least 2");
  end
  if (COL_WIDTH != 8 && COL_WIDTH != 9) begin : g_bad_col
    $error("COL_WIDTH must be 8 or 9");
  end

  logic a_acc, b_acc, a_wr, b_wr, same_addr;
  logic [DataWidth-1:0] a_old, b_old, a_merged, b_merged;

  assign a_acc     = a_req_i & ~rst_i;
  assign b_acc     = b_req_i & ~rst_i;
  assign a_wr      = a_acc & a_we_i;
  assign b_wr      = b_acc & b_we_i;
  assign same_addr = (a_addr_i == b_addr_i);

  for (genvar i = 0; i < NB_COL; i++) begin : g_col
    logic [COL_WIDTH-1:0] ram_q [RAM_DEPTH];
    logic a_col_we, b_col_we;

    assign a_col_we = a_wr & a_be_i[i];
    // Port A owns any byte both ports write to the same word in the same cycle.
    assign b_col_we = b_wr & b_be_i[i] & ~(a_col_we & same_addr);

    always_ff @(posedge clk_i) begin
      if (a_col_we) ram_q[a_addr_i] <= a_wdata_i[i*COL_WIDTH +: COL_WIDTH];
      if (b_col_we) ram_q[b_addr_i] <= b_wdata_i[i*COL_WIDTH +: COL_WIDTH];
    end

    // Reads see the pre-edge word, which gives read-first behaviour across ports.
    assign a_old[i*COL_WIDTH +: COL_WIDTH]    = ram_q[a_addr_i];
    assign b_old[i*COL_WIDTH +: COL_WIDTH]    = ram_q[b_addr_i];
    assign a_merged[i*COL_WIDTH +: COL_WIDTH] =
        a_be_i[i] ? a_wdata_i[i*COL_WIDTH +: COL_WIDTH] : a_old[i*COL_WIDTH +: COL_WIDTH];
    assign b_merged[i*COL_WIDTH +: COL_WIDTH] =
        b_be_i[i] ? b_wdata_i[i*COL_WIDTH +: COL_WIDTH] : b_old[i*COL_WIDTH +: COL_WIDTH];
  end

  logic                 a_s0_load, b_s0_load;
  logic [DataWidth-1:0] a_s0_data, b_s0_data;

  always_comb begin
    a_s0_load = a_acc & ~(a_we_i & (WRITE_MODE_A == NO_CHANGE));
    b_s0_load = b_acc & ~(b_we_i & (WRITE_MODE_B == NO_CHANGE));
    a_s0_data = (a_we_i && WRITE_MODE_A == WR_FIRST) ? a_merged : a_old;
    b_s0_data = (b_we_i && WRITE_MODE_B == WR_FIRST) ? b_merged : b_old;
  end

  bram_out_pipe #(
    .DataWidth (DataWidth),
    .Stages    (READ_LATENCY)
  ) u_pipe_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (a_s0_load),
    .data_i  (a_s0_data),
    .data_o  (a_rdata_o),
    .valid_o (a_rvalid_o)
  );

  bram_out_pipe #(
    .DataWidth (DataWidth),
    .Stages    (READ_LATENCY)
  ) u_pipe_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (b_s0_load),
    .data_i  (b_s0_data),
    .data_o  (b_rdata_o),
    .valid_o (b_rvalid_o)
  );

  logic collision_d, collision_q;

  assign collision_d = a_acc & b_acc & same_addr & (a_we_i | b_we_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) collision_q <= 1'b0;
    else       collision_q <= collision_d;
  end

  assign collision_o = collision_q;

endmodule

// File: tb/tb_xilinx_dp_bram_pipe.sv
// Directed bench: four instances share stimulus (WR_FIRST/RD_FIRST/NO_CHANGE on A, plus latency 3).
module tb_xilinx_dp_bram_pipe;
  import bram_pkg::*;

  localparam int NVEC = 14;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_be, b_be;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic [31:0] a_rdata [4];
  logic [31:0] b_rdata [4];
  logic [3:0]  a_rvalid, b_rvalid, coll;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  // 0: WR_FIRST lat 2, 1: RD_FIRST lat 2, 2: NO_CHANGE lat 2, 3: WR_FIRST lat 3
  for (genvar g = 0; g < 4; g++) begin : g_dut
    xilinx_dp_bram_pipe #(
      .NB_COL       (4),
      .COL_WIDTH    (8),
      .RAM_DEPTH    (1024),
      .READ_LATENCY ((g == 3) ? 3 : 2),
      .WRITE_MODE_A ((g == 1) ? RD_FIRST : ((g == 2) ? NO_CHANGE : WR_FIRST)),
      .WRITE_MODE_B (WR_FIRST)
    ) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .a_req_i     (a_req),
      .a_we_i      (a_we),
      .a_be_i      (a_be),
      .a_addr_i    (a_addr),
      .a_wdata_i   (a_wdata),
      .a_rdata_o   (a_rdata[g]),
      .a_rvalid_o  (a_rvalid[g]),
      .b_req_i     (b_req),
      .b_we_i      (b_we),
      .b_be_i      (b_be),
      .b_addr_i    (b_addr),
      .b_wdata_i   (b_wdata),
      .b_rdata_o   (b_rdata[g]),
      .b_rvalid_o  (b_rvalid[g]),
      .collision_o (coll[g])
    );
  end

  typedef struct {
    logic        a_req, a_we;
    logic [3:0]  a_be;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_req, b_we;
    logic [3:0]  b_be;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata;
    logic        ea_v;
    logic [31:0] ea_d;
    logic        eb_v;
    logic [31:0] eb_d;
    logic        e_col;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 10'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 10'h0; b_wdata = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_we = v.a_we; a_be = v.a_be; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_be = v.b_be; b_addr = v.b_addr; b_wdata = v.b_wdata;
  endtask

  task automatic port_a(input logic we, input logic [3:0] be, input logic [9:0] addr,
                        input logic [31:0] wdata);
    a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // a_req a_we a_be a_addr a_wdata | b_req b_we b_be b_addr b_wdata | ea_v ea_d eb_v eb_d col
    vecs[0]  = '{1'b1, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                 1'b1, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 10'h010, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                 1'b1, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'h3, 10'h010, 32'h0000CAFE, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                 1'b1, 32'hDEADCAFE, 1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0,
                 1'b0, 32'hDEADCAFE, 1'b1, 32'hDEADCAFE, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 10'h020, 32'h0, 1'b1, 1'b1, 4'hF, 10'h030, 32'h12345678,
                 1'b1, 32'h00000000, 1'b1, 32'h12345678, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'hC, 10'h020, 32'hAAAAAAAA, 1'b1, 1'b1, 4'h6, 10'h020, 32'hBBBBBBBB,
                 1'b1, 32'hAAAA0000, 1'b1, 32'h00BBBB00, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 10'h020, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                 1'b1, 32'hAAAABB00, 1'b0, 32'h00BBBB00, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'hF, 10'h030, 32'h0, 1'b1, 1'b0, 4'h0, 10'h030, 32'h0,
                 1'b1, 32'h00000000, 1'b1, 32'h12345678, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 4'h0, 10'h030, 32'h0,
                 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 10'h020, 32'h0, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0,
                 1'b1, 32'hAAAABB00, 1'b1, 32'hAAAABB00, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'h0, 10'h020, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0,
                 1'b1, 32'hAAAABB00, 1'b1, 32'hAAAABB00, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 4'hF, 10'h020, 32'h00000001, 1'b0, 1'b1, 4'hF, 10'h020, 32'h1,
                 1'b0, 32'hAAAABB00, 1'b0, 32'hAAAABB00, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 10'h020, 32'h0, 1'b1, 1'b1, 4'hF, 10'h3FF, 32'h0F0F0F0F,
                 1'b1, 32'hAAAABB00, 1'b1, 32'h0F0F0F0F, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0, 1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0,
                 1'b1, 32'h0F0F0F0F, 1'b1, 32'h0F0F0F0F, 1'b0};

    idle();
    rst_i = 1'b1;
    step();
    step();
    chk("reset a_rdata", a_rdata[0], 32'h0);
    chk1("reset a_rvalid", a_rvalid[0], 1'b0);
    chk("reset b_rdata", b_rdata[0], 32'h0);
    chk1("reset b_rvalid", b_rvalid[0], 1'b0);
    chk1("reset collision", coll[0], 1'b0);
    rst_i = 1'b0;
    step();

    // Table: request at edge E, collision after E, read data after E+1 (latency 2).
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      step();
      idle();
      chk1($sformatf("v%0d collision", i), coll[0], vecs[i].e_col);
      chk1($sformatf("v%0d a_rvalid early", i), a_rvalid[0], 1'b0);
      chk1($sformatf("v%0d b_rvalid early", i), b_rvalid[0], 1'b0);
      step();
      chk1($sformatf("v%0d collision gone", i), coll[0], 1'b0);
      chk1($sformatf("v%0d a_rvalid", i), a_rvalid[0], vecs[i].ea_v);
      chk($sformatf("v%0d a_rdata", i), a_rdata[0], vecs[i].ea_d);
      chk1($sformatf("v%0d b_rvalid", i), b_rvalid[0], vecs[i].eb_v);
      chk($sformatf("v%0d b_rdata", i), b_rdata[0], vecs[i].eb_d);
      step();
    end

    // Write modes on port A, old word 0xDEADCAFE at 0x10.
    port_a(1'b0, 4'h0, 10'h010, 32'h0);
    step();
    idle();
    step();
    for (int g = 0; g < 3; g++) begin
      chk1($sformatf("mode%0d pre-read rvalid", g), a_rvalid[g], 1'b1);
      chk($sformatf("mode%0d pre-read rdata", g), a_rdata[g], 32'hDEADCAFE);
    end
    step();
    port_a(1'b1, 4'hF, 10'h010, 32'h11223344);
    step();
    idle();
    chk1("no_change rvalid early", a_rvalid[2], 1'b0);
    step();
    chk1("wr_first rvalid", a_rvalid[0], 1'b1);
    chk("wr_first rdata", a_rdata[0], 32'h11223344);
    chk1("rd_first rvalid", a_rvalid[1], 1'b1);
    chk("rd_first rdata", a_rdata[1], 32'hDEADCAFE);
    chk1("no_change rvalid", a_rvalid[2], 1'b0);
    chk("no_change rdata held", a_rdata[2], 32'hDEADCAFE);
    step();
    port_a(1'b0, 4'h0, 10'h010, 32'h0);
    step();
    idle();
    step();
    chk("no_change write landed", a_rdata[2], 32'h11223344);
    step();

    // Latency 3: fill words 0..3, stream reads, then reset with reads in flight.
    for (int i = 0; i < 4; i++) begin
      port_a(1'b1, 4'hF, 10'(i), 32'hA0000000 | 32'(i));
      step();
    end
    idle();
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      port_a(1'b0, 4'h0, 10'(i), 32'h0);
      step();
      if (i >= 2) begin
        chk1($sformatf("lat3 stream rvalid %0d", i - 2), a_rvalid[3], 1'b1);
        chk($sformatf("lat3 stream rdata %0d", i - 2), a_rdata[3], 32'hA0000000 | 32'(i - 2));
      end
    end
    rst_i = 1'b1;
    port_a(1'b1, 4'hF, 10'h000, 32'hFFFFFFFF);
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h000;
    step();
    idle();
    rst_i = 1'b0;
    chk("rst a_rdata", a_rdata[3], 32'h0);
    chk1("rst a_rvalid", a_rvalid[3], 1'b0);
    chk("rst b_rdata", b_rdata[3], 32'h0);
    chk1("rst b_rvalid", b_rvalid[3], 1'b0);
    chk1("rst collision", coll[3], 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk1($sformatf("no stale a_rvalid c%0d", c), a_rvalid[3], 1'b0);
      chk1($sformatf("no stale b_rvalid c%0d", c), b_rvalid[3], 1'b0);
      chk1($sformatf("no collision after rst c%0d", c), coll[3], 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      port_a(1'b0, 4'h0, 10'(i), 32'h0);
      step();
      idle();
      step();
      step();
      chk1($sformatf("reread rvalid %0d", i), a_rvalid[3], 1'b1);
      chk($sformatf("reread rdata %0d", i), a_rdata[3], 32'hA0000000 | 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
